// File: rtl/hash160_pkg.sv
// Shared types and defaults for the Hash160 request scheduler.
package hash160_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT,
        ST_RESP
    } state_t;

    localparam int BLOCK_W     = 512;
    localparam int DIGEST_W    = 160;
    localparam int TIMEOUT_DEF = 1024;

endpackage

// File: rtl/hash160_rr_pick.sv
// Combinational round-robin picker: first valid requester after last_gnt, wrapping.
module hash160_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [ID_W-1:0]    last_gnt,
    output logic [NUM_REQ-1:0] gnt,
    output logic [ID_W-1:0]    gnt_idx,
    output logic               any_valid
);

    logic            hi_found;
    logic            lo_found;
    logic [ID_W-1:0] hi_idx;
    logic [ID_W-1:0] lo_idx;

    // Two ascending scans: indices above the pointer win over the wrapped-around ones.
    always_comb begin
        hi_found = 1'b0;
        lo_found = 1'b0;
        hi_idx   = '0;
        lo_idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (req_valid[i]) begin
                if ((ID_W'(i) > last_gnt) && !hi_found) begin
                    hi_found = 1'b1;
                    hi_idx   = ID_W'(i);
                end
                if ((ID_W'(i) <= last_gnt) && !lo_found) begin
                    lo_found = 1'b1;
                    lo_idx   = ID_W'(i);
                end
            end
        end
        gnt_idx   = hi_found ? hi_idx : lo_idx;
        any_valid = hi_found | lo_found;
        gnt       = '0;
        if (any_valid) begin
            gnt[gnt_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/hash160_sched.sv
// Round-robin scheduler sharing one Hash160 core among NUM_REQ requesters,
// with a watchdog on core completion and a valid/ready response channel.
module hash160_sched
    import hash160_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int BLOCK_W  = hash160_pkg::BLOCK_W,
    parameter int DIGEST_W = hash160_pkg::DIGEST_W,
    parameter int TIMEOUT  = hash160_pkg::TIMEOUT_DEF,
    parameter int ID_W     = $clog2(NUM_REQ)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ*BLOCK_W-1:0] req_block,
    output logic                       core_start,
    output logic [BLOCK_W-1:0]         core_block,
    input  logic                       core_done,
    input  logic [DIGEST_W-1:0]        core_digest,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [ID_W-1:0]            rsp_id,
    output logic [DIGEST_W-1:0]        rsp_digest,
    output logic                       rsp_error,
    output logic                       busy
);

    localparam int              CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t               state;
    state_t               state_nxt;
    logic [ID_W-1:0]      last_gnt;
    logic [CNT_W-1:0]     wd_cnt;
    logic                 wd_expired;
    logic [NUM_REQ-1:0]   pick_gnt;
    logic [ID_W-1:0]      pick_idx;
    logic                 pick_any;

    // Watchdog count stops at its terminal value instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_LAST) ? v : v + 1'b1;
    endfunction

    hash160_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_pick (
        .req_valid (req_valid),
        .last_gnt  (last_gnt),
        .gnt       (pick_gnt),
        .gnt_idx   (pick_idx),
        .any_valid (pick_any)
    );

    assign wd_expired = (wd_cnt == CNT_LAST);

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_start = 1'b0;
        rsp_valid  = 1'b0;
        busy       = 1'b1;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (!rst) begin
                    req_ready = pick_gnt;
                end
                if (pick_any) begin
                    state_nxt = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                core_start = 1'b1;
                state_nxt  = ST_WAIT;
            end
            ST_WAIT: begin
                if (core_done || wd_expired) begin
                    state_nxt = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            last_gnt   <= ID_W'(NUM_REQ - 1);
            wd_cnt     <= '0;
            core_block <= '0;
            rsp_id     <= '0;
            rsp_digest <= '0;
            rsp_error  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (pick_any) begin
                        core_block <= req_block[pick_idx*BLOCK_W +: BLOCK_W];
                        rsp_id     <= pick_idx;
                        last_gnt   <= pick_idx;
                    end
                end
                ST_ISSUE: begin
                    wd_cnt <= '0;
                end
                ST_WAIT: begin
                    wd_cnt <= sat_inc(wd_cnt);
                    // A completion on the expiry cycle still delivers the digest.
                    if (core_done) begin
                        rsp_digest <= core_digest;
                        rsp_error  <= 1'b0;
                    end else if (wd_expired) begin
                        rsp_digest <= '0;
                        rsp_error  <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
